pdm_cic_receiver: RTL and testbench

- Microphone-side PDM front end: generates the PDM mic clock, samples the 1-bit mic data stream, and decimates it to signed 16-bit PCM with a 3rd-order CIC filter.
- It is the receive end of the PDM link that the team's pdm modulator drives.
- Output strobes feed the fir_decimator chain directly, or any consumer using audio_in/audio_sample_valid semantics.

---
 rtl/pdm_pkg.sv | 20 ++
 rtl/pdm_clk_gen.sv | 47 ++++
 rtl/pdm_cic_receiver.sv | 138 +++++++++++++
 tb/tb_pdm_cic_receiver.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared constants, types and helpers for the PDM receive path.
// Imported by the clock generator and the CIC receiver top.
package pdm_pkg;

    localparam int PDM_COUNT_PERIOD_DEF = 32;
    localparam int DECIMATION_DEF       = 64;
    localparam int PCM_W                = 16;
    localparam int CIC_ORDER            = 3;

    typedef logic signed [PCM_W-1:0] pcm_t;

    localparam pcm_t PCM_MAX = 16'sh7fff;
    localparam pcm_t PCM_MIN = 16'sh8000;

    // Integrator width that absorbs the full CIC gain of DECIMATION^ORDER.
    function automatic int cic_acc_w(input int decimation);
        return 2 + CIC_ORDER * $clog2(decimation);
    endfunction

endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: mic clock divider, per-sample tick and data synchronizer.
// The tick marks the last low cycle of each mic clock period.
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int PERIOD = PDM_COUNT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic mic_data,
    output logic mic_clk,
    output logic tick,
    output logic sample_bit
);

    localparam int CW   = $clog2(PERIOD);
    localparam int HALF = PERIOD / 2;

    logic [CW-1:0] m;
    logic [CW-1:0] m_next;
    logic [1:0]    sync;

    always_comb begin
        m_next = '0;
        if (enable && (m != CW'(PERIOD - 1))) begin
            m_next = m + CW'(1);
        end
    end

    // mic_clk is registered from m_next so it is high exactly while m < HALF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m       <= '0;
            mic_clk <= 1'b0;
            sync    <= '0;
        end else begin
            m       <= m_next;
            mic_clk <= enable & (m_next < CW'(HALF));
            sync    <= {sync[0], mic_data};
        end
    end

    assign tick       = (m == CW'(PERIOD - 1));
    assign sample_bit = sync[1];

endmodule

// File: rtl/pdm_cic_receiver.sv
// pdm_cic_receiver: PDM mic front end with a 3rd-order CIC decimator.
// Turns the 1-bit mic stream into signed 16-bit PCM strobes.
module pdm_cic_receiver
    import pdm_pkg::*;
#(
    parameter int PDM_COUNT_PERIOD = PDM_COUNT_PERIOD_DEF,
    parameter int DECIMATION       = DECIMATION_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_in_n,
    input  logic                    enable_in,
    input  logic                    mic_data_in,
    output logic                    mic_clk_out,
    output logic                    pdm_tick_out,
    output logic signed [PCM_W-1:0] pcm_out,
    output logic                    pcm_valid_out,
    output logic                    sat_out
);

    localparam int LOG2_DEC = $clog2(DECIMATION);
    localparam int ACC_W    = cic_acc_w(DECIMATION);
    localparam int SHIFT    = CIC_ORDER * LOG2_DEC - (PCM_W - 1);

    typedef logic signed [ACC_W-1:0] acc_t;

    logic                tick;
    logic                sample_bit;
    logic                dec;
    logic                frame_end;
    logic [LOG2_DEC-1:0] k;

    acc_t x;
    acc_t i1, i2, i3;
    acc_t i1_n, i2_n, i3_n;
    acc_t d1, d2, d3;
    acc_t c1, c2, c3;
    acc_t scaled;
    pcm_t pcm_next;
    logic clip;

    pdm_clk_gen #(
        .PERIOD(PDM_COUNT_PERIOD)
    ) u_clk_gen (
        .clk       (clk_in),
        .rst_n     (rst_in_n),
        .enable    (enable_in),
        .mic_data  (mic_data_in),
        .mic_clk   (mic_clk_out),
        .tick      (tick),
        .sample_bit(sample_bit)
    );

    assign pdm_tick_out = tick;
    assign frame_end    = &k;

    // Integrators wrap modulo 2^ACC_W; the comb differences undo the wrap.
    always_comb begin
        x    = sample_bit ? acc_t'(1) : '1;
        i1_n = i1 + x;
        i2_n = i2 + i1_n;
        i3_n = i3 + i2_n;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            k   <= '0;
            dec <= 1'b0;
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
        end else if (!enable_in) begin
            k   <= '0;
            dec <= 1'b0;
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
        end else begin
            dec <= tick & frame_end;
            if (tick) begin
                k  <= k + LOG2_DEC'(1);
                i1 <= i1_n;
                i2 <= i2_n;
                i3 <= i3_n;
            end
        end
    end

    always_comb begin
        c1 = i3 - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (!enable_in) begin
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (dec) begin
            d1 <= i3;
            d2 <= c1;
            d3 <= c2;
        end
    end

    // Full-scale ones lands one LSB above PCM_MAX, so the clamp is live.
    always_comb begin
        scaled   = c3 >>> SHIFT;
        pcm_next = scaled[PCM_W-1:0];
        clip     = 1'b0;
        if (scaled > acc_t'(PCM_MAX)) begin
            pcm_next = PCM_MAX;
            clip     = 1'b1;
        end else if (scaled < acc_t'(PCM_MIN)) begin
            pcm_next = PCM_MIN;
            clip     = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            pcm_out       <= '0;
            pcm_valid_out <= 1'b0;
            sat_out       <= 1'b0;
        end else begin
            pcm_valid_out <= enable_in & dec;
            if (enable_in & dec) begin
                pcm_out <= pcm_next;
                sat_out <= sat_out | clip;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_receiver.sv
// tb_pdm_cic_receiver: drives mic bit streams and compares PCM output
// against a direct box^3 convolution model of the CIC decimator.
module tb_pdm_cic_receiver;

    localparam int D      = 64;
    localparam int SH     = 3;
    localparam int KLEN   = 3 * D - 2;
    localparam int FRAME  = D * 32;
    localparam int M_ZERO = 0;
    localparam int M_ONE  = 1;
    localparam int M_ALT  = 2;
    localparam int M_SD   = 3;
    localparam int M_RND  = 4;

    logic clk_in      = 1'b0;
    logic rst_in_n    = 1'b1;
    logic enable_in   = 1'b0;
    logic mic_data_in = 1'b0;
    logic mic_clk_out;
    logic pdm_tick_out;
    logic pcm_valid_out;
    logic sat_out;
    logic signed [15:0] pcm_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          h[KLEN];
    int          xs[$];
    logic [15:0] pcm_q[$];
    int          vt_q[$];
    int          mode;
    int          sd_acc;
    logic        cur_bit;

    pdm_cic_receiver dut (
        .clk_in       (clk_in),
        .rst_in_n     (rst_in_n),
        .enable_in    (enable_in),
        .mic_data_in  (mic_data_in),
        .mic_clk_out  (mic_clk_out),
        .pdm_tick_out (pdm_tick_out),
        .pcm_out      (pcm_out),
        .pcm_valid_out(pcm_valid_out),
        .sat_out      (sat_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic gen_bit();
        case (mode)
            M_ZERO: cur_bit = 1'b0;
            M_ONE:  cur_bit = 1'b1;
            M_ALT:  cur_bit = (xs.size() % 2) == 0;
            M_SD: begin
                cur_bit = (sd_acc >= 0);
                sd_acc += cur_bit ? -64 : 192;
            end
            default: cur_bit = ($urandom & 1) != 0;
        endcase
        mic_data_in = cur_bit;
    endtask

    task automatic prep_stream(input int md);
        mode = md;
        xs.delete();
        pcm_q.delete();
        vt_q.delete();
        sd_acc = int'($urandom_range(0, 127)) - 64;
        gen_bit();
    endtask

    task automatic start_stream(input int md);
        prep_stream(md);
        repeat (3) @(negedge clk_in);
        enable_in = 1'b1;
    endtask

    task automatic run_frames(input int n_out);
        int cyc;
        int limit;
        cyc   = 0;
        limit = 2100 + n_out * FRAME;
        while (pcm_q.size() < n_out && cyc < limit) begin
            @(negedge clk_in);
            cyc++;
            if (pdm_tick_out === 1'b1) begin
                xs.push_back(cur_bit ? 1 : -1);
                gen_bit();
            end
            if (pcm_valid_out === 1'b1) begin
                pcm_q.push_back(pcm_out);
                vt_q.push_back(cyc);
            end
        end
        n_checks++;
        if (pcm_q.size() != n_out) begin
            n_fail++;
            $display("FAIL run_frames: got %0d outputs, expected %0d",
                     pcm_q.size(), n_out);
        end
    endtask

    // Output n = box^3 kernel applied to the samples ending at tick n*D+D-1.
    function automatic int model_pcm(input int n, output bit clip);
        int t;
        int acc;
        int v;
        t   = n * D + D - 1;
        acc = 0;
        for (int j = 0; j < KLEN; j++) begin
            if (t - j >= 0 && t - j < xs.size()) acc += h[j] * xs[t-j];
        end
        v    = acc >>> SH;
        clip = 1'b0;
        if (v > 32767) begin
            v    = 32767;
            clip = 1'b1;
        end else if (v < -32768) begin
            v    = -32768;
            clip = 1'b1;
        end
        return v;
    endfunction

    task automatic test_reset();
        logic seen;
        int   highs;
        int   early;
        enable_in = 1'b1;
        #2 rst_in_n = 1'b0;
        #1;
        n_checks++;
        if ({mic_clk_out, pdm_tick_out, pcm_valid_out, sat_out} !== 4'b0
            || pcm_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got clk=%b tick=%b v=%b sat=%b pcm=%0d, expected all 0",
                     mic_clk_out, pdm_tick_out, pcm_valid_out, sat_out, pcm_out);
        end
        repeat (3) @(negedge clk_in);
        rst_in_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk_in);
            seen = (pdm_tick_out === 1'b1);
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL first_tick: got none in 64 cycles, expected one");
        end
        for (int p = 0; p < 2; p++) begin
            highs = 0;
            early = 0;
            n_checks++;
            if (mic_clk_out !== 1'b0) begin
                n_fail++;
                $display("FAIL clk_at_tick: got %b, expected 0", mic_clk_out);
            end
            for (int c = 1; c <= 32; c++) begin
                @(negedge clk_in);
                if (mic_clk_out === 1'b1) highs++;
                if (c < 32 && pdm_tick_out !== 1'b0) early++;
                if (c == 1) begin
                    n_checks++;
                    if (mic_clk_out !== 1'b1) begin
                        n_fail++;
                        $display("FAIL clk_after_tick: got %b, expected 1", mic_clk_out);
                    end
                end
            end
            n_checks++;
            if (highs != 16) begin
                n_fail++;
                $display("FAIL clk_high_count: got %0d, expected 16", highs);
            end
            n_checks++;
            if (early != 0 || pdm_tick_out !== 1'b1) begin
                n_fail++;
                $display("FAIL tick_period: got early=%0d tick32=%b, expected 0 and 1",
                         early, pdm_tick_out);
            end
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_all_zeros();
        bit clip;
        bit any_clip;
        int e;
        any_clip = 1'b0;
        start_stream(M_ZERO);
        run_frames(5);
        for (int i = 0; i < pcm_q.size(); i++) begin
            e = model_pcm(i, clip);
            any_clip |= clip;
            n_checks++;
            if (pcm_q[i] !== 16'(e)) begin
                n_fail++;
                $display("FAIL zeros_pcm[%0d]: got %0d, expected %0d", i, $signed(pcm_q[i]), e);
            end
            if (i >= 3) begin
                n_checks++;
                if (pcm_q[i] !== 16'h8000) begin
                    n_fail++;
                    $display("FAIL zeros_full[%0d]: got %0d, expected -32768", i, $signed(pcm_q[i]));
                end
            end
        end
        n_checks++;
        if (sat_out !== any_clip) begin
            n_fail++;
            $display("FAIL zeros_sat: got %b, expected %b", sat_out, any_clip);
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_alternating();
        bit clip;
        int e;
        start_stream(M_ALT);
        run_frames(5);
        for (int i = 0; i < pcm_q.size(); i++) begin
            e = model_pcm(i, clip);
            n_checks++;
            if (pcm_q[i] !== 16'(e)) begin
                n_fail++;
                $display("FAIL alt_pcm[%0d]: got %0d, expected %0d", i, $signed(pcm_q[i]), e);
            end
            if (i >= 3) begin
                n_checks++;
                if (pcm_q[i] !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL alt_zero[%0d]: got %0d, expected 0", i, $signed(pcm_q[i]));
                end
            end
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_reference_loop();
        bit clip;
        bit any_clip;
        int e;
        int v;
        any_clip = 1'b0;
        start_stream(M_SD);
        run_frames(6);
        for (int i = 0; i < pcm_q.size(); i++) begin
            e = model_pcm(i, clip);
            any_clip |= clip;
            v = $signed(pcm_q[i]);
            n_checks++;
            if (pcm_q[i] !== 16'(e)) begin
                n_fail++;
                $display("FAIL ref_pcm[%0d]: got %0d, expected %0d", i, v, e);
            end
            if (i >= 3) begin
                n_checks++;
                if (v < 16384 - 256 || v > 16384 + 256) begin
                    n_fail++;
                    $display("FAIL ref_level[%0d]: got %0d, expected 16384+-256", i, v);
                end
            end
        end
        n_checks++;
        if (sat_out !== any_clip) begin
            n_fail++;
            $display("FAIL ref_sat: got %b, expected %b", sat_out, any_clip);
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_random_stream();
        bit clip;
        int e;
        start_stream(M_RND);
        run_frames(4);
        for (int i = 0; i < pcm_q.size(); i++) begin
            e = model_pcm(i, clip);
            n_checks++;
            if (pcm_q[i] !== 16'(e)) begin
                n_fail++;
                $display("FAIL rnd_pcm[%0d]: got %0d, expected %0d", i, $signed(pcm_q[i]), e);
            end
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_all_ones();
        bit clip;
        bit any_clip;
        int e;
        any_clip = 1'b0;
        start_stream(M_ONE);
        run_frames(5);
        for (int i = 0; i < pcm_q.size(); i++) begin
            e = model_pcm(i, clip);
            any_clip |= clip;
            n_checks++;
            if (pcm_q[i] !== 16'(e)) begin
                n_fail++;
                $display("FAIL ones_pcm[%0d]: got %0d, expected %0d", i, $signed(pcm_q[i]), e);
            end
            if (i >= 3) begin
                n_checks++;
                if (pcm_q[i] !== 16'h7fff) begin
                    n_fail++;
                    $display("FAIL ones_full[%0d]: got %0d, expected 32767", i, $signed(pcm_q[i]));
                end
            end
            if (i >= 1) begin
                n_checks++;
                if (vt_q[i] - vt_q[i-1] != FRAME) begin
                    n_fail++;
                    $display("FAIL ones_interval[%0d]: got %0d, expected %0d",
                             i, vt_q[i] - vt_q[i-1], FRAME);
                end
            end
        end
        n_checks++;
        if (sat_out !== 1'b1 || !any_clip) begin
            n_fail++;
            $display("FAIL ones_sat: got %b, expected 1", sat_out);
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_enable_mid_frame();
        bit clip;
        int e;
        start_stream(M_ONE);
        repeat (1000) @(negedge clk_in);
        enable_in = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if ({mic_clk_out, pdm_tick_out, pcm_valid_out} !== 3'b000) begin
            n_fail++;
            $display("FAIL dis_idle: got clk=%b tick=%b v=%b, expected 000",
                     mic_clk_out, pdm_tick_out, pcm_valid_out);
        end
        n_checks++;
        if (pcm_out !== 16'sh7fff || sat_out !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_hold: got pcm=%0d sat=%b, expected 32767 1", pcm_out, sat_out);
        end
        prep_stream(M_ONE);
        repeat (9) begin
            @(negedge clk_in);
            n_checks++;
            if ({mic_clk_out, pdm_tick_out, pcm_valid_out} !== 3'b000) begin
                n_fail++;
                $display("FAIL dis_quiet: got clk=%b tick=%b v=%b, expected 000",
                         mic_clk_out, pdm_tick_out, pcm_valid_out);
            end
        end
        enable_in = 1'b1;
        run_frames(4);
        n_checks++;
        if (vt_q.size() == 0 || vt_q[0] < FRAME) begin
            n_fail++;
            $display("FAIL en_latency: got %0d, expected >= %0d",
                     (vt_q.size() == 0) ? -1 : vt_q[0], FRAME);
        end
        for (int i = 0; i < 3 && i < pcm_q.size(); i++) begin
            e = model_pcm(i, clip);
            n_checks++;
            if (pcm_q[i] !== 16'(e)) begin
                n_fail++;
                $display("FAIL en_pcm[%0d]: got %0d, expected %0d", i, $signed(pcm_q[i]), e);
            end
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid_frame();
        bit clip;
        bit any_clip;
        int e;
        any_clip = 1'b0;
        start_stream(M_ONE);
        repeat (3000) @(negedge clk_in);
        rst_in_n = 1'b0;
        #1;
        n_checks++;
        if ({mic_clk_out, pdm_tick_out, pcm_valid_out, sat_out} !== 4'b0
            || pcm_out !== 16'sd0) begin
            n_fail++;
            $display("FAIL rst_async: got clk=%b tick=%b v=%b sat=%b pcm=%0d, expected all 0",
                     mic_clk_out, pdm_tick_out, pcm_valid_out, sat_out, pcm_out);
        end
        repeat (3) @(negedge clk_in);
        prep_stream(M_ONE);
        @(negedge clk_in);
        rst_in_n = 1'b1;
        run_frames(4);
        n_checks++;
        if (vt_q.size() == 0 || vt_q[0] < FRAME) begin
            n_fail++;
            $display("FAIL rst_latency: got %0d, expected >= %0d",
                     (vt_q.size() == 0) ? -1 : vt_q[0], FRAME);
        end
        for (int i = 0; i < pcm_q.size(); i++) begin
            e = model_pcm(i, clip);
            any_clip |= clip;
            if (i < 3) begin
                n_checks++;
                if (pcm_q[i] !== 16'(e)) begin
                    n_fail++;
                    $display("FAIL rst_pcm[%0d]: got %0d, expected %0d", i, $signed(pcm_q[i]), e);
                end
            end
        end
        n_checks++;
        if (sat_out !== any_clip) begin
            n_fail++;
            $display("FAIL rst_sat: got %b, expected %b", sat_out, any_clip);
        end
        enable_in = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        for (int j = 0; j < KLEN; j++) h[j] = 0;
        for (int a = 0; a < D; a++)
            for (int b = 0; b < D; b++)
                for (int c = 0; c < D; c++)
                    h[a+b+c]++;

        test_reset();
        test_all_zeros();
        test_alternating();
        test_reference_loop();
        test_random_stream();
        test_all_ones();
        test_enable_mid_frame();
        test_reset_mid_frame();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
